// File: rtl/tx_slot_scheduler_if.sv
// Requester handshake and transmitter slot bus of the TX slot scheduler.
// master: requester / transmitter side; slave: the scheduler itself.
interface tx_slot_scheduler_if;
  logic [3:0]  i_req_valid;
  logic [51:0] i_req_data;
  logic [3:0]  o_req_ready;
  logic [15:0] o_tx_data1;
  logic [15:0] o_tx_data2;
  logic [1:0]  o_slot_fill;

  modport master (
    output i_req_valid, i_req_data,
    input  o_req_ready, o_tx_data1, o_tx_data2, o_slot_fill
  );

  modport slave (
    input  i_req_valid, i_req_data,
    output o_req_ready, o_tx_data1, o_tx_data2, o_slot_fill
  );
endinterface

// File: rtl/tx_slot_scheduler.sv
// Round-robin scheduler filling the two 16-bit payload slots of the serial
// transmitter from 4 requesters once per K28.5 frame. Slots clear on the
// frame strobe, filling stops on SFP fault, and a watchdog flags a missing
// frame strobe.
module tx_slot_scheduler #(
  parameter int unsigned SYNC_TIMEOUT = 16383
) (
  input  logic                 i_clk,
  input  logic                 i_res_n,
  input  logic                 i_frame_sync,
  input  logic                 i_sfp_tx_flt,
  tx_slot_scheduler_if.slave   bus,
  output logic                 o_sync_lost
);

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    FILL1     = 2'd1,
    FILL2     = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam logic [13:0] CNT_MAX = '1;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_ptr;
  logic [1:0]  w_win;
  logic        w_any;
  logic        w_grant;
  logic [3:0]  w_ready;
  logic [12:0] w_pay;
  logic [15:0] w_word;
  logic [15:0] r_tx_data1;
  logic [15:0] r_tx_data2;
  logic [1:0]  r_slot_fill;
  logic [13:0] r_sync_cnt;
  logic [13:0] w_sync_cnt_nxt;
  logic        r_sync_lost;

  // Round-robin pick: first valid requester after the last grant, wrapping.
  // Scanning from the farthest offset down lets the nearest one win.
  always_comb begin : arb
    logic [1:0] v_idx;
    w_any = |bus.i_req_valid;
    w_win = r_ptr + 2'd1;
    v_idx = '0;
    for (int unsigned i = 4; i >= 1; i--) begin
      v_idx = r_ptr + 2'(i);
      if (bus.i_req_valid[v_idx]) begin
        w_win = v_idx;
      end
    end
  end

  // Payload of the winner and its formatted slot word.
  always_comb begin
    w_pay  = bus.i_req_data[13*w_win +: 13];
    w_word = {1'b1, w_win, w_pay};
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      r_state <= WAIT_SYNC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and grant: fault beats sync, sync beats any grant.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    if (i_sfp_tx_flt) begin
      w_state_nxt = WAIT_SYNC;
    end else if (i_frame_sync) begin
      w_state_nxt = FILL1;
    end else begin
      case (r_state)
        FILL1: begin
          if (w_any) begin
            w_grant     = 1'b1;
            w_state_nxt = FILL2;
          end
        end
        FILL2: begin
          if (w_any) begin
            w_grant     = 1'b1;
            w_state_nxt = DONE;
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
    w_ready = w_grant ? (4'b0001 << w_win) : '0;
  end

  // Slot registers, fill flags and round-robin pointer.
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      r_tx_data1  <= '0;
      r_tx_data2  <= '0;
      r_slot_fill <= '0;
      r_ptr       <= 2'd3;
    end else if (i_sfp_tx_flt || i_frame_sync) begin
      r_tx_data1  <= '0;
      r_tx_data2  <= '0;
      r_slot_fill <= '0;
    end else if (w_grant) begin
      r_ptr <= w_win;
      if (r_state == FILL1) begin
        r_tx_data1     <= w_word;
        r_slot_fill[0] <= 1'b1;
      end else begin
        r_tx_data2     <= w_word;
        r_slot_fill[1] <= 1'b1;
      end
    end
  end

  // Frame-strobe watchdog counter, saturating.
  always_comb begin
    if (i_frame_sync) begin
      w_sync_cnt_nxt = '0;
    end else if (r_sync_cnt == CNT_MAX) begin
      w_sync_cnt_nxt = r_sync_cnt;
    end else begin
      w_sync_cnt_nxt = r_sync_cnt + 14'd1;
    end
  end

  // Watchdog registers; the flag tracks the counter value it is stored with.
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      r_sync_cnt  <= '0;
      r_sync_lost <= 1'b0;
    end else begin
      r_sync_cnt  <= w_sync_cnt_nxt;
      r_sync_lost <= (32'(w_sync_cnt_nxt) >= SYNC_TIMEOUT);
    end
  end

  assign bus.o_req_ready = w_ready;
  assign bus.o_tx_data1  = r_tx_data1;
  assign bus.o_tx_data2  = r_tx_data2;
  assign bus.o_slot_fill = r_slot_fill;
  assign o_sync_lost     = r_sync_lost;

endmodule

// File: tb/tb_tx_slot_scheduler.sv
// Testbench for tx_slot_scheduler: directed frames with literal expectations,
// then randomized requesters/sync/fault checked every cycle against a
// behavioural model, then a long sync-free stretch for the watchdog.
module tb_tx_slot_scheduler;

  localparam int unsigned TO = 16383;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sync;
  logic        flt;
  logic        o_lost;
  logic [3:0]  valid;
  logic [12:0] pay [4];

  tx_slot_scheduler_if bif ();

  assign bif.i_req_valid = valid;
  assign bif.i_req_data  = {pay[3], pay[2], pay[1], pay[0]};

  tx_slot_scheduler #(.SYNC_TIMEOUT(TO)) dut (
    .i_clk        (clk),
    .i_res_n      (rst_n),
    .i_frame_sync (sync),
    .i_sfp_tx_flt (flt),
    .bus          (bif.slave),
    .o_sync_lost  (o_lost)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: armed = a sync was seen since reset/fault, n = slots filled so far.
  bit          m_armed;
  int          m_n;
  int          m_ptr;
  logic [15:0] m_slot [2];
  int          m_cnt;
  bit          m_lost;
  logic [3:0]  m_granted;
  logic [3:0]  last_ready;
  bit          auto_req;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_armed   = 0;
    m_n       = 0;
    m_ptr     = 3;
    m_slot[0] = '0;
    m_slot[1] = '0;
    m_cnt     = 0;
    m_lost    = 0;
    m_granted = '0;
  endtask

  function automatic logic [3:0] exp_ready();
    if (flt || sync || !m_armed || m_n >= 2 || valid == 4'b0) return 4'b0;
    for (int d = 1; d <= 4; d++) begin
      int c;
      c = (m_ptr + d) % 4;
      if (valid[c]) return 4'(1 << c);
    end
    return 4'b0;
  endfunction

  task automatic check_outputs();
    logic [1:0] ef;
    ef[0] = (m_n >= 1);
    ef[1] = (m_n >= 2);
    chk("ready", 32'(bif.o_req_ready), 32'(exp_ready()));
    chk("tx_data1", 32'(bif.o_tx_data1), 32'(m_slot[0]));
    chk("tx_data2", 32'(bif.o_tx_data2), 32'(m_slot[1]));
    chk("slot_fill", 32'(bif.o_slot_fill), 32'(ef));
    chk("sync_lost", 32'(o_lost), 32'(m_lost));
    last_ready = bif.o_req_ready;
  endtask

  task automatic model_edge();
    logic [3:0] g;
    g = exp_ready();
    m_cnt  = sync ? 0 : ((m_cnt < 16383) ? m_cnt + 1 : 16383);
    m_lost = (m_cnt >= int'(TO));
    if (flt) begin
      m_slot[0] = '0; m_slot[1] = '0; m_n = 0; m_armed = 0;
    end else if (sync) begin
      m_slot[0] = '0; m_slot[1] = '0; m_n = 0; m_armed = 1;
    end else if (g != 4'b0) begin
      for (int c = 0; c < 4; c++) begin
        if (g[c]) begin
          m_slot[m_n] = {1'b1, 2'(c), pay[c]};
          m_ptr = c;
        end
      end
      m_n++;
    end
    m_granted = g;
  endtask

  task automatic req_update();
    if (!auto_req) return;
    for (int c = 0; c < 4; c++) begin
      if (m_granted[c]) begin
        valid[c] = ($urandom % 4 != 0);
        pay[c]   = 13'($urandom);
      end else if (valid[c]) begin
        if ($urandom % 16 == 0) valid[c] = 1'b0;
      end else if ($urandom % 4 == 0) begin
        valid[c] = 1'b1;
        pay[c]   = 13'($urandom);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
    req_update();
  endtask

  initial begin
    int fcnt;
    int period;
    rst_n = 1'b0; sync = 1'b0; flt = 1'b0; valid = '0; auto_req = 0;
    for (int c = 0; c < 4; c++) pay[c] = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #3;
    chk("rst_ready", 32'(bif.o_req_ready), 32'h0);
    chk("rst_tx1", 32'(bif.o_tx_data1), 32'h0);
    chk("rst_fill", 32'(bif.o_slot_fill), 32'h0);
    chk("rst_lost", 32'(o_lost), 32'h0);
    rst_n = 1'b1;

    // Frame with ch0 and ch2 pending.
    sync = 1'b1; step(); sync = 1'b0;
    valid = 4'b0101; pay[0] = 13'h0ABC; pay[2] = 13'h1234;
    step(); chk("t1_ready0", 32'(last_ready), 32'h1);
    valid = 4'b0100;
    step(); chk("t1_ready2", 32'(last_ready), 32'h4);
    valid = 4'b0000;
    chk("t1_tx1", 32'(bif.o_tx_data1), 32'h8ABC);
    chk("t1_tx2", 32'(bif.o_tx_data2), 32'hD234);
    chk("t1_fill", 32'(bif.o_slot_fill), 32'h3);
    valid = 4'b0010; pay[1] = 13'h0005;
    step(); chk("done_noready", 32'(last_ready), 32'h0);

    // Ch1 valid coincides with sync: no grant until next cycle.
    sync = 1'b1; step(); sync = 1'b0;
    chk("sync_noready", 32'(last_ready), 32'h0);
    chk("sync_clr_tx1", 32'(bif.o_tx_data1), 32'h0);
    chk("sync_clr_tx2", 32'(bif.o_tx_data2), 32'h0);
    step(); chk("ch1_ready", 32'(last_ready), 32'h2);
    chk("ch1_tx1", 32'(bif.o_tx_data1), 32'hA005);

    // Fault during FILL2.
    valid = 4'b1000; pay[3] = 13'h0007; flt = 1'b1;
    step(); chk("flt_noready", 32'(last_ready), 32'h0);
    chk("flt_tx1", 32'(bif.o_tx_data1), 32'h0);
    chk("flt_fill", 32'(bif.o_slot_fill), 32'h0);
    flt = 1'b0;
    step(); chk("post_flt_noready", 32'(last_ready), 32'h0);
    sync = 1'b1; step(); sync = 1'b0;
    chk("resync_noready", 32'(last_ready), 32'h0);

    // Only ch3 requesting, re-presenting for slot 2.
    step(); chk("ch3_ready_a", 32'(last_ready), 32'h8);
    chk("ch3_tx1", 32'(bif.o_tx_data1), 32'hE007);
    pay[3] = 13'h1FFF;
    step(); chk("ch3_ready_b", 32'(last_ready), 32'h8);
    chk("ch3_tx2", 32'(bif.o_tx_data2), 32'hFFFF);
    chk("ch3_fill", 32'(bif.o_slot_fill), 32'h3);

    // Asynchronous reset mid-frame.
    rst_n = 1'b0;
    #1;
    chk("arst_tx1", 32'(bif.o_tx_data1), 32'h0);
    chk("arst_tx2", 32'(bif.o_tx_data2), 32'h0);
    chk("arst_fill", 32'(bif.o_slot_fill), 32'h0);
    model_reset();
    #2 rst_n = 1'b1;
    step(); chk("arst_noready", 32'(last_ready), 32'h0);

    // All four requesting over three frames: 0,1 | 2,3 | 0,1.
    valid = 4'b1111;
    for (int c = 0; c < 4; c++) pay[c] = 13'(16'h0100 * c + 3);
    sync = 1'b1; step(); sync = 1'b0;
    step(); chk("rr_f1_a", 32'(last_ready), 32'h1);
    step(); chk("rr_f1_b", 32'(last_ready), 32'h2);
    step(); chk("rr_f1_done", 32'(last_ready), 32'h0);
    sync = 1'b1; step(); sync = 1'b0;
    chk("rr_clr", 32'(bif.o_slot_fill), 32'h0);
    step(); chk("rr_f2_a", 32'(last_ready), 32'h4);
    step(); chk("rr_f2_b", 32'(last_ready), 32'h8);
    sync = 1'b1; step(); sync = 1'b0;
    step(); chk("rr_f3_a", 32'(last_ready), 32'h1);
    step(); chk("rr_f3_b", 32'(last_ready), 32'h2);

    // Randomized requesters, frame strobes and faults.
    auto_req = 1;
    fcnt = 0;
    period = 8;
    for (int unsigned cyc = 0; cyc < 3000; cyc++) begin
      if (fcnt >= period) begin
        sync = 1'b1; fcnt = 0; period = int'($urandom_range(3, 14));
      end else begin
        sync = 1'b0; fcnt++;
      end
      if (flt) flt = ($urandom % 4 != 0);
      else     flt = ($urandom % 80 == 0);
      step();
    end
    sync = 1'b0; flt = 1'b0;

    // Watchdog: stop the frame strobe.
    sync = 1'b1; step(); sync = 1'b0;
    repeat (int'(TO) - 1) step();
    chk("wd_before", 32'(o_lost), 32'h0);
    step();
    chk("wd_rise", 32'(o_lost), 32'h1);
    repeat (5) step();
    chk("wd_sat", 32'(o_lost), 32'h1);
    sync = 1'b1; step(); sync = 1'b0;
    chk("wd_fall", 32'(o_lost), 32'h0);
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_slot_scheduler.md
Name: tx_slot_scheduler

Overview:
- Round-robin scheduler that shares the two 16-bit payload slots of the slave serial transmitter among 4 requesters (e.g. current ADC, bus voltage, temperature, status).
- Each K28.5 frame it fills slot 1, then slot 2, from pending requests using a valid/ready handshake.
- Slot contents are held stable until the transmitter latches them on the frame strobe; the slots then clear and the next fill begins.
- Sits between the sensor front-ends and the serial transmitter's i_tx_data1/i_tx_data2 inputs. Also gates on SFP fault and detects a missing frame strobe.

Parameters:
- SYNC_TIMEOUT, 16383: clocks without i_frame_sync before o_sync_lost asserts (nominal frame 10240 clocks at 40 MHz); counter 14 bits, saturating.

Ports:
- i_clk  in  1  40 MHz system clock
- i_res_n  in  1  asynchronous active-low reset
- i_frame_sync  in  1  one-clock pulse, same cycle the transmitter latches its data inputs (K28.5 slot)
- i_sfp_tx_flt  in  1  SFP transmitter fault, active high
- i_req_valid  in  4  per-requester valid
- i_req_data  in  52  4 x 13-bit payloads; requester k on bits [13k+12:13k]
- o_req_ready  out  4  one-hot accept pulse; the payload is captured in the cycle ready and valid are both high
- o_tx_data1  out  16  slot 1 word, to the transmitter's i_tx_data1
- o_tx_data2  out  16  slot 2 word, to the transmitter's i_tx_data2
- o_slot_fill  out  2  bit0 = slot 1 filled, bit1 = slot 2 filled
- o_sync_lost  out  1  frame strobe missing for at least SYNC_TIMEOUT clocks

Behaviour:
- Reset values: all outputs 0; state WAIT_SYNC; RR pointer (last grant) = 3, so ch0 has first priority; sync counter 0.
- Word format: {1'b1, ch[1:0], payload[12:0]}. An empty slot is 16'h0000. Outputs are registers and change only on clock edges.
- State WAIT_SYNC: no grants. On i_frame_sync -> FILL1.
- State FILL1: if any valid, grant the RR winner (first valid index after the pointer, modulo 4).
  - o_req_ready[winner] = 1 combinationally, that cycle only.
  - At the edge: o_tx_data1 <= formatted word, o_slot_fill[0] <= 1, pointer <= winner, -> FILL2.
  - If no valid, stay in FILL1.
- State FILL2: same as FILL1 but writes o_tx_data2 and o_slot_fill[1], then -> DONE.
  - The same channel may win both slots if it is the only one requesting (after its FILL1 grant it re-presents valid with new data).
- State DONE: no grants; slot registers hold.
- i_frame_sync in FILL1/FILL2/DONE:
  - At that edge, slots clear to 0 and o_slot_fill clears to 0; -> FILL1.
  - o_req_ready is forced 0 in the sync cycle (sync has priority over grant).
  - The transmitter samples pre-edge slot values, so a payload accepted during frame N is transmitted in frame N+1.
  - Unfilled slots go out as 16'h0000.
- At most one grant per cycle. o_req_ready is never asserted without the matching valid.
- Requesters hold valid and data stable until ready. Dropping valid without ready is legal; nothing is captured.
- Fault (i_sfp_tx_flt = 1): in any state, o_req_ready forced 0. At each edge: slots and o_slot_fill cleared, state <= WAIT_SYNC, pointer held.
  - After the fault deasserts, filling restarts only at the next i_frame_sync.
  - Sync and fault in the same cycle: fault wins.
- Sync watchdog:
  - Counter clears to 0 on i_frame_sync and otherwise increments, saturating at 2^14-1.
  - o_sync_lost is registered: it is 1 once the counter reaches SYNC_TIMEOUT, and 0 on the edge after a sync.
  - The watchdog is independent of fault and is not reset by it.
- Asynchronous reset mid-frame returns everything to the reset values immediately. No grant is issued until the first sync after reset.

Test Plan:
- Reset, then pulse sync. Ch0 data 0x0ABC and ch2 data 0x1234 both valid. -> Ready ch0 then ch2 in consecutive cycles; o_tx_data1=16'h8ABC, o_tx_data2=16'hD234, o_slot_fill=2'b11. DONE: no further ready.
- All 4 valid continuously over 3 frames. -> Grant order 0,1 | 2,3 | 0,1. Each sync clears the slots to 0000 on the edge after the sync cycle.
- Only ch3 valid, re-presenting each time. -> Both slots ch3: o_tx_data1=o_tx_data2=16'hE000|payload, with payloads from successive handshakes.
- Ch1 asserts valid in the same cycle as sync. -> o_req_ready=0 that cycle; granted the next cycle in FILL1.
- Fault asserted during FILL2 with slot 1 filled. -> Slots clear to 0, no ready. After release, no grant until the next sync; then ready resumes.
- Sync stopped for 16383 clocks. -> o_sync_lost rises at count 16383. The next sync pulse drops it on the following edge.
